// File: rtl/cpu_pkg.sv
// Shared constants and stage state encoding for the 16-bit pipelined CPU.
package cpu_pkg;
  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 8;
  localparam int CPU_REG_W  = 3;
  localparam int CPU_CNT_W  = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } stage_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data memory from the EX/MEM entry, builds the MEM/WB
// register, traps out-of-range memory ops into FAULT and counts retired loads/stores.
//
// Handshake: an EX/MEM entry transfers on a posedge where ex_valid && ex_ready;
// ex_ready is low during wb_stall, in FAULT and while reset_n is low, and upstream
// must hold its entry unchanged until it transfers. wb_valid presents one MEM/WB
// entry per cycle; wb_stall freezes it.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int REG_W  = CPU_REG_W,
  parameter int CNT_W  = CPU_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  output logic              ex_ready,
  input  logic              wb_stall,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault,
  output logic [DATA_W-1:0] fault_addr,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count,
  output stage_state_t      dbg_state
);
  stage_state_t      r_state;
  stage_state_t      w_state_nxt;
  logic              w_run;
  logic              w_ready;
  logic              w_addr_ok;
  logic              w_accept;
  logic              w_memop;
  logic              w_fault_evt;
  logic              w_is_load;
  logic              w_ld_inc;
  logic              w_st_inc;
  logic              r_wb_valid;
  logic [REG_W-1:0]  r_wb_rd;
  logic              r_wb_reg_write;
  logic [DATA_W-1:0] r_wb_data;
  logic [DATA_W-1:0] r_fault_addr;

  // A set store bit wins when both op bits are asserted.
  assign w_is_load   = ex_is_load & ~ex_is_store;
  assign w_addr_ok   = (ex_alu[DATA_W-1:ADDR_W] == '0);
  assign w_accept    = ex_valid & w_ready;
  assign w_memop     = w_accept & (ex_is_load | ex_is_store);
  assign w_fault_evt = w_memop & ~w_addr_ok;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_RUN;
    end else if (w_fault_evt) begin
      w_state_nxt = ST_FAULT;
    end
  end

  // reset_n gates ready so nothing is written to memory during a reset cycle.
  always_comb begin
    w_run   = (r_state == ST_RUN);
    w_ready = reset_n & ~wb_stall & w_run;
    fault   = ~w_run;
  end

  assign ex_ready    = w_ready;
  assign mem_address = ex_alu[ADDR_W-1:0];
  assign mem_wdata   = ex_store_data;
  assign mem_we      = ex_valid & ex_is_store & w_addr_ok & w_ready;
  assign dbg_state   = r_state;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_data      <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
    end else if (!wb_stall) begin
      if (w_accept && !w_fault_evt) begin
        r_wb_valid     <= 1'b1;
        r_wb_rd        <= ex_rd;
        r_wb_reg_write <= ex_reg_write & ~ex_is_store;
        r_wb_data      <= w_is_load ? mem_rdata : ex_alu;
      end else begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fault_addr <= '0;
    end else if (w_fault_evt && !flush) begin
      r_fault_addr <= ex_alu;
    end
  end

  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_data      = r_wb_data;
  assign fault_addr   = r_fault_addr;

  // A flushed entry is discarded, so it does not retire and is not counted.
  assign w_ld_inc = w_memop & w_addr_ok & w_is_load & ~flush;
  assign w_st_inc = w_memop & w_addr_ok & ex_is_store & ~flush;

  sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk   (clock),
    .rst_n (reset_n),
    .inc   (w_ld_inc),
    .count (load_count)
  );

  sat_counter #(.W(CNT_W)) u_store_cnt (
    .clk   (clock),
    .rst_n (reset_n),
    .inc   (w_st_inc),
    .count (store_count)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a negedge-acting 256x16 data memory.
module tb_mem_access_stage;
  import cpu_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [15:0] ex_alu;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_ready;
  logic        wb_stall;
  logic [7:0]  mem_address;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic        wb_reg_write;
  logic [15:0] wb_data;
  logic        fault;
  logic [15:0] fault_addr;
  logic [15:0] load_count;
  logic [15:0] store_count;
  stage_state_t dbg_state;

  logic        s_ex_ready, s_mem_we, s_wb_valid, s_wb_reg_write, s_fault;
  logic [7:0]  s_mem_address;
  logic [15:0] s_mem_wdata, s_wb_data, s_fault_addr;
  logic [2:0]  s_wb_rd;
  logic [3:0]  s_load_count, s_store_count;
  stage_state_t s_dbg_state;

  logic [15:0] mem [256];

  int n_pass;
  int n_total;

  mem_access_stage u_dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_alu(ex_alu),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_ready(ex_ready), .wb_stall(wb_stall), .mem_address(mem_address),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .fault(fault), .fault_addr(fault_addr),
    .load_count(load_count), .store_count(store_count), .dbg_state(dbg_state)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  mem_access_stage #(.CNT_W(4)) u_dut_small (
    .clock(clock), .reset_n(reset_n), .flush(flush), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_alu(ex_alu),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_ready(s_ex_ready), .wb_stall(wb_stall), .mem_address(s_mem_address),
    .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .wb_reg_write(s_wb_reg_write),
    .wb_data(s_wb_data), .fault(s_fault), .fault_addr(s_fault_addr),
    .load_count(s_load_count), .store_count(s_store_count), .dbg_state(s_dbg_state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: write and registered read both on negedge.
  always @(negedge clock) begin
    if (mem_we) mem[mem_address] <= mem_wdata;
    mem_rdata <= mem[mem_address];
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    flush = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_alu = 16'h0000; ex_store_data = 16'h0000; ex_rd = 3'd0; ex_reg_write = 1'b0;
    wb_stall = 1'b0;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [15:0] alu,
                          input logic [15:0] sd, input logic [2:0] rd, input logic rw);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_alu = alu;
    ex_store_data = sd; ex_rd = rd; ex_reg_write = rw;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    drive_op(1'b0, 1'b1, 16'h0010, 16'hDEAD, 3'd1, 1'b0);
    #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
    n_total++; if (ex_ready !== 1'b0) $display("FAIL rst_ex_ready: got %b want 0", ex_ready); else n_pass++;
    step();
    step();
    n_total++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %b want 0", wb_valid); else n_pass++;
    n_total++; if (wb_rd !== 3'd0) $display("FAIL rst_wb_rd: got %0d want 0", wb_rd); else n_pass++;
    n_total++; if (wb_reg_write !== 1'b0) $display("FAIL rst_wb_reg_write: got %b want 0", wb_reg_write); else n_pass++;
    n_total++; if (wb_data !== 16'h0000) $display("FAIL rst_wb_data: got %h want 0000", wb_data); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault); else n_pass++;
    n_total++; if (fault_addr !== 16'h0000) $display("FAIL rst_fault_addr: got %h want 0000", fault_addr); else n_pass++;
    n_total++; if (load_count !== 16'd0) $display("FAIL rst_load_count: got %0d want 0", load_count); else n_pass++;
    n_total++; if (store_count !== 16'd0) $display("FAIL rst_store_count: got %0d want 0", store_count); else n_pass++;
    n_total++; if (dbg_state !== ST_RUN) $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_RUN); else n_pass++;
    n_total++; if (mem[8'h10] !== 16'hA010) $display("FAIL rst_no_write: got %h want a010", mem[8'h10]); else n_pass++;
    drive_idle();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_store_load();
    drive_op(1'b0, 1'b1, 16'h00A5, 16'h1234, 3'd1, 1'b1);
    #1;
    n_total++; if (mem_we !== 1'b1) $display("FAIL sl_mem_we: got %b want 1", mem_we); else n_pass++;
    n_total++; if (mem_address !== 8'hA5) $display("FAIL sl_mem_address: got %h want a5", mem_address); else n_pass++;
    n_total++; if (mem_wdata !== 16'h1234) $display("FAIL sl_mem_wdata: got %h want 1234", mem_wdata); else n_pass++;
    step();
    n_total++; if (wb_reg_write !== 1'b0) $display("FAIL sl_store_rw: got %b want 0", wb_reg_write); else n_pass++;
    n_total++; if (store_count !== 16'd1) $display("FAIL sl_store_count: got %0d want 1", store_count); else n_pass++;
    drive_op(1'b1, 1'b0, 16'h00A5, 16'h0000, 3'd2, 1'b1);
    step();
    n_total++; if (wb_valid !== 1'b1) $display("FAIL sl_load_valid: got %b want 1", wb_valid); else n_pass++;
    n_total++; if (wb_data !== 16'h1234) $display("FAIL sl_load_data: got %h want 1234", wb_data); else n_pass++;
    n_total++; if (wb_rd !== 3'd2) $display("FAIL sl_load_rd: got %0d want 2", wb_rd); else n_pass++;
    n_total++; if (wb_reg_write !== 1'b1) $display("FAIL sl_load_rw: got %b want 1", wb_reg_write); else n_pass++;
    n_total++; if (load_count !== 16'd1) $display("FAIL sl_load_count: got %0d want 1", load_count); else n_pass++;
    // Both op bits set: behaves as a store.
    drive_op(1'b1, 1'b1, 16'h00B0, 16'h4321, 3'd6, 1'b1);
    #1;
    n_total++; if (mem_we !== 1'b1) $display("FAIL both_mem_we: got %b want 1", mem_we); else n_pass++;
    step();
    n_total++; if (wb_reg_write !== 1'b0) $display("FAIL both_rw: got %b want 0", wb_reg_write); else n_pass++;
    n_total++; if (store_count !== 16'd2) $display("FAIL both_store_count: got %0d want 2", store_count); else n_pass++;
    n_total++; if (load_count !== 16'd1) $display("FAIL both_load_count: got %0d want 1", load_count); else n_pass++;
    n_total++; if (mem[8'hB0] !== 16'h4321) $display("FAIL both_mem: got %h want 4321", mem[8'hB0]); else n_pass++;
  endtask

  task automatic test_alu();
    drive_op(1'b0, 1'b0, 16'h7777, 16'h9999, 3'd3, 1'b1);
    #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL alu_mem_we: got %b want 0", mem_we); else n_pass++;
    step();
    n_total++; if (wb_valid !== 1'b1) $display("FAIL alu_valid: got %b want 1", wb_valid); else n_pass++;
    n_total++; if (wb_rd !== 3'd3) $display("FAIL alu_rd: got %0d want 3", wb_rd); else n_pass++;
    n_total++; if (wb_data !== 16'h7777) $display("FAIL alu_data: got %h want 7777", wb_data); else n_pass++;
    n_total++; if (wb_reg_write !== 1'b1) $display("FAIL alu_rw: got %b want 1", wb_reg_write); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL alu_no_fault: got %b want 0", fault); else n_pass++;
    n_total++; if (load_count !== 16'd1 || store_count !== 16'd2)
      $display("FAIL alu_counts: got %0d/%0d want 1/2", load_count, store_count); else n_pass++;
    drive_idle();
    step();
    n_total++; if (wb_valid !== 1'b0) $display("FAIL bubble_valid: got %b want 0", wb_valid); else n_pass++;
  endtask

  task automatic test_stall();
    drive_op(1'b1, 1'b0, 16'h0020, 16'h0000, 3'd4, 1'b1);
    step();
    n_total++; if (wb_data !== 16'hA020) $display("FAIL stall_pre_data: got %h want a020", wb_data); else n_pass++;
    drive_op(1'b1, 1'b0, 16'h0030, 16'h0000, 3'd5, 1'b1);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (ex_ready !== 1'b0 || mem_we !== 1'b0)
        $display("FAIL stall_ready_we[%0d]: got %b/%b want 0/0", i, ex_ready, mem_we); else n_pass++;
      step();
      n_total++; if (wb_valid !== 1'b1 || wb_rd !== 3'd4 || wb_data !== 16'hA020 || wb_reg_write !== 1'b1)
        $display("FAIL stall_hold[%0d]: got %b/%0d/%h/%b want 1/4/a020/1", i, wb_valid, wb_rd, wb_data, wb_reg_write);
      else n_pass++;
    end
    n_total++; if (load_count !== 16'd2) $display("FAIL stall_load_count: got %0d want 2", load_count); else n_pass++;
    wb_stall = 1'b0;
    step();
    n_total++; if (wb_data !== 16'hA030 || wb_rd !== 3'd5) $display("FAIL stall_release: got %h/%0d want a030/5", wb_data, wb_rd); else n_pass++;
    n_total++; if (load_count !== 16'd3) $display("FAIL stall_rel_count: got %0d want 3", load_count); else n_pass++;
    drive_op(1'b0, 1'b1, 16'h0040, 16'hFFFF, 3'd0, 1'b0);
    wb_stall = 1'b1;
    #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL stall_store_we: got %b want 0", mem_we); else n_pass++;
    step();
    n_total++; if (mem[8'h40] !== 16'hA040) $display("FAIL stall_store_mem: got %h want a040", mem[8'h40]); else n_pass++;
    wb_stall = 1'b0;
    #1;
    n_total++; if (mem_we !== 1'b1) $display("FAIL stall_store_rel_we: got %b want 1", mem_we); else n_pass++;
    step();
    n_total++; if (mem[8'h40] !== 16'hFFFF) $display("FAIL stall_store_rel_mem: got %h want ffff", mem[8'h40]); else n_pass++;
    n_total++; if (store_count !== 16'd3) $display("FAIL stall_store_count: got %0d want 3", store_count); else n_pass++;
  endtask

  task automatic test_fault();
    drive_op(1'b0, 1'b1, 16'h0100, 16'h5555, 3'd1, 1'b0);
    #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL flt_mem_we: got %b want 0", mem_we); else n_pass++;
    step();
    n_total++; if (fault !== 1'b1) $display("FAIL flt_fault: got %b want 1", fault); else n_pass++;
    n_total++; if (fault_addr !== 16'h0100) $display("FAIL flt_addr: got %h want 0100", fault_addr); else n_pass++;
    n_total++; if (wb_valid !== 1'b0) $display("FAIL flt_wb_valid: got %b want 0", wb_valid); else n_pass++;
    n_total++; if (dbg_state !== ST_FAULT) $display("FAIL flt_state: got %0d want %0d", dbg_state, ST_FAULT); else n_pass++;
    n_total++; if (mem[8'h00] !== 16'hA000) $display("FAIL flt_mem0: got %h want a000", mem[8'h00]); else n_pass++;
    n_total++; if (store_count !== 16'd3) $display("FAIL flt_store_count: got %0d want 3", store_count); else n_pass++;
    drive_op(1'b0, 1'b1, 16'h0050, 16'h6666, 3'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++; if (ex_ready !== 1'b0 || mem_we !== 1'b0)
        $display("FAIL flt_park[%0d]: got %b/%b want 0/0", i, ex_ready, mem_we); else n_pass++;
      step();
    end
    n_total++; if (wb_valid !== 1'b0 || mem[8'h50] !== 16'hA050)
      $display("FAIL flt_park_out: got %b/%h want 0/a050", wb_valid, mem[8'h50]); else n_pass++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_total++; if (fault !== 1'b0 || dbg_state !== ST_RUN) $display("FAIL flush_run: got %b/%0d want 0/0", fault, dbg_state); else n_pass++;
    n_total++; if (wb_valid !== 1'b0) $display("FAIL flush_wb_valid: got %b want 0", wb_valid); else n_pass++;
    n_total++; if (fault_addr !== 16'h0100) $display("FAIL flush_addr_held: got %h want 0100", fault_addr); else n_pass++;
    n_total++; if (store_count !== 16'd3) $display("FAIL flush_count: got %0d want 3", store_count); else n_pass++;
    drive_op(1'b0, 1'b0, 16'h0123, 16'h0000, 3'd7, 1'b1);
    #1;
    n_total++; if (ex_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", ex_ready); else n_pass++;
    step();
    n_total++; if (wb_valid !== 1'b1 || wb_data !== 16'h0123) $display("FAIL flush_resume: got %b/%h want 1/0123", wb_valid, wb_data); else n_pass++;
    drive_idle();
  endtask

  task automatic test_saturation();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_op(1'b1, 1'b0, 16'(i), 16'h0000, 3'd1, 1'b1);
      step();
    end
    drive_idle();
    step();
    n_total++; if (s_load_count !== 4'd15) $display("FAIL sat_small: got %0d want 15", s_load_count); else n_pass++;
    n_total++; if (load_count !== 16'd20) $display("FAIL sat_wide: got %0d want 20", load_count); else n_pass++;
  endtask

  task automatic test_reset_in_fault();
    drive_op(1'b1, 1'b0, 16'h0200, 16'h0000, 3'd2, 1'b1);
    step();
    n_total++; if (fault !== 1'b1) $display("FAIL rf_fault: got %b want 1", fault); else n_pass++;
    drive_op(1'b0, 1'b1, 16'h0055, 16'h7E7E, 3'd0, 1'b0);
    reset_n = 1'b0;
    #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rf_we_early: got %b want 0", mem_we); else n_pass++;
    @(negedge clock);
    #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rf_we_negedge: got %b want 0", mem_we); else n_pass++;
    step();
    n_total++; if (fault !== 1'b0 || fault_addr !== 16'h0000 || dbg_state !== ST_RUN)
      $display("FAIL rf_fault_clear: got %b/%h/%0d want 0/0000/0", fault, fault_addr, dbg_state); else n_pass++;
    n_total++; if (wb_valid !== 1'b0 || wb_rd !== 3'd0 || wb_data !== 16'h0000 || wb_reg_write !== 1'b0)
      $display("FAIL rf_wb_clear: got %b/%0d/%h/%b want 0/0/0000/0", wb_valid, wb_rd, wb_data, wb_reg_write); else n_pass++;
    n_total++; if (load_count !== 16'd0 || store_count !== 16'd0)
      $display("FAIL rf_counts: got %0d/%0d want 0/0", load_count, store_count); else n_pass++;
    n_total++; if (mem[8'h55] !== 16'hA055) $display("FAIL rf_mem: got %h want a055", mem[8'h55]); else n_pass++;
    drive_idle();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    reset_n = 1'b0;
    drive_idle();
    test_reset();
    test_store_load();
    test_alu();
    test_stall();
    test_fault();
    test_saturation();
    test_reset_in_fault();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
